mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
Memory-side responder for one core's instruction and data cache request ports. It accepts iREN/iaddr from the icache and dREN/dWEN/daddr/dstore from the dcache. It arbitrates between them and runs one single-word RAM transaction at a time over a ready-handshaked RAM port. Completion is signalled to the requester by dropping iwait/dwait for exactly one cycle, with load data valid in that cycle.

Parameters:
TIMEOUT, 64, max cycles an access may wait for ramready before it is force-completed with an error
ERR_WORD, 32'hBAD0BAD0, load value returned on a timed-out read

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  reset, asynchronous, active-low
iREN  in  1  icache read request
iaddr  in  32  icache word address
iwait  out  1  low for one cycle when the icache read completes
iload  out  32  instruction word, valid while iwait low
dREN  in  1  dcache read request
dWEN  in  1  dcache write request (wins over dREN if both high)
daddr  in  32  dcache word address
dstore  in  32  dcache write data
dwait  out  1  low for one cycle when the dcache access completes
dload  out  32  read data, valid while dwait low; 0 for writes
ramREN  out  1  RAM read strobe
ramWEN  out  1  RAM write strobe
ramaddr  out  32  RAM address
ramstore  out  32  RAM write data
ramload  in  32  RAM read data, valid with ramready
ramready  in  1  RAM access complete this cycle
err  out  1  sticky timeout flag

Behaviour:
- States: IDLE, IACC, DACC. Reset → IDLE, last_d=0, counter=0, err=0. While reset: iwait=dwait=1, loads=0, ram strobes/addr/store=0.
- Default outputs, every state: iwait=1, dwait=1, iload=0, dload=0. Ram outputs are 0 unless in an ACC state.
- IDLE arbitration, registered:
  - Only D pending (dREN|dWEN) → DACC.
  - Only iREN → IACC.
  - Both pending → grant the side not served last: last_d=1 → IACC, else DACC.
  - On grant: latch address, dstore and op (write if dWEN) into holding registers; counter=0.
- No request is serviced in IDLE, so minimum latency is request high at cycle 0 → ACC at cycle 1 → completion in the cycle ramready is sampled high.
- IACC:
  - ramREN=1, ramaddr=latched addr.
  - If ramready: iwait=0, iload=ramload (combinational, same cycle). Next state IDLE, last_d=0.
- DACC:
  - Write: ramWEN=1, ramstore=latched data.
  - Read: ramREN=1.
  - ramaddr=latched addr.
  - If ramready: dwait=0, and dload=ramload for reads. Next state IDLE, last_d=1.
- After each completion there is exactly one IDLE bubble cycle before the next grant.
- Withdrawal: if the granted side's enable drops before ramready, abort. Ram strobes are dropped next cycle, there is no wait pulse, next state IDLE, and last_d is unchanged.
- Timeout:
  - Counter increments each ACC cycle without ramready.
  - When counter == TIMEOUT-1 and still no ramready: force completion. Wait goes low for one cycle, the load returns ERR_WORD on reads (writes return 0), err is set, next state IDLE.
  - err clears only on reset.
- ramready in IDLE is ignored.
- Address or data changes on the request ports mid-access are ignored; the latched values are used.
- Reset asserted mid-access: immediate return to IDLE with reset outputs; the interrupted access is not completed.

Test Plan:
- Icache read only: iREN=1, iaddr=0x40, ramready high 3 cycles after grant with ramload=0x2002_0001 → ramREN/ramaddr=0x40 for 3 cycles, iwait low exactly 1 cycle with iload=0x2002_0001, dwait stays 1.
- Write beats read: dWEN=dREN=1, daddr=0x80, dstore=0xDEADBEEF → ramWEN=1, ramREN=0, ramstore=0xDEADBEEF; dwait pulse with dload=0.
- Simultaneous requests, reset state: iREN and dREN held with ramready=1 every ACC cycle → grant order D, I, D, I, with one idle bubble between each.
- Withdrawal: iREN dropped 2 cycles into IACC, ramready never seen → strobes drop next cycle, no iwait pulse, err=0.
- Timeout with TIMEOUT=8: dREN held and ramready=0 → dwait low on the 8th DACC cycle, dload=0xBAD0BAD0, err=1 and stays 1 until nRST.
- Reset mid-DACC: nRST pulsed low → ramWEN/ramREN=0 immediately, iwait=dwait=1, state IDLE, err=0.

Source files
------------

// File: rtl/mem_responder.sv
// Memory-side responder for one core: arbitrates icache/dcache requests onto a
// single ready-handshaked RAM port, one word at a time, with a timeout guard.
module mem_responder #(
  parameter int          TIMEOUT  = 64,
  parameter logic [31:0] ERR_WORD = 32'hBAD0BAD0
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ramready,
  output logic        err
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, IACC, DACC} state_t;

  state_t             state, state_next;
  logic               last_d, last_d_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic               err_next;
  logic               grant_i, grant_d;
  logic [31:0]        hold_addr, hold_data;
  logic               hold_wr;
  logic               d_req, timed_out;

  assign d_req     = dREN | dWEN;
  assign timed_out = (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      last_d <= 1'b0;
      cnt    <= '0;
      err    <= 1'b0;
    end else begin
      state  <= state_next;
      last_d <= last_d_next;
      cnt    <= cnt_next;
      err    <= err_next;
    end
  end

  // Request fields are captured at grant so later port changes cannot disturb the access.
  always_ff @(posedge CLK) begin
    if (grant_d) begin
      hold_addr <= daddr;
      hold_data <= dstore;
      hold_wr   <= dWEN;
    end else if (grant_i) begin
      hold_addr <= iaddr;
      hold_wr   <= 1'b0;
    end
  end

  always_comb begin
    state_next  = state;
    last_d_next = last_d;
    cnt_next    = cnt;
    err_next    = err;
    grant_i     = 1'b0;
    grant_d     = 1'b0;
    iwait       = 1'b1;
    dwait       = 1'b1;
    iload       = '0;
    dload       = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    case (state)
      IDLE: begin
        // On contention the side not served last wins.
        if (d_req && (!iREN || !last_d)) begin
          grant_d    = 1'b1;
          state_next = DACC;
          cnt_next   = '0;
        end else if (iREN) begin
          grant_i    = 1'b1;
          state_next = IACC;
          cnt_next   = '0;
        end
      end
      IACC: begin
        ramREN  = 1'b1;
        ramaddr = hold_addr;
        if (ramready) begin
          iwait       = 1'b0;
          iload       = ramload;
          state_next  = IDLE;
          last_d_next = 1'b0;
        end else if (!iREN) begin
          state_next = IDLE;
        end else if (timed_out) begin
          iwait       = 1'b0;
          iload       = ERR_WORD;
          err_next    = 1'b1;
          state_next  = IDLE;
          last_d_next = 1'b0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      DACC: begin
        ramREN   = ~hold_wr;
        ramWEN   = hold_wr;
        ramstore = hold_wr ? hold_data : '0;
        ramaddr  = hold_addr;
        if (ramready) begin
          dwait       = 1'b0;
          dload       = hold_wr ? '0 : ramload;
          state_next  = IDLE;
          last_d_next = 1'b1;
        end else if (!d_req) begin
          state_next = IDLE;
        end else if (timed_out) begin
          dwait       = 1'b0;
          dload       = hold_wr ? '0 : ERR_WORD;
          err_next    = 1'b1;
          state_next  = IDLE;
          last_d_next = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: arbitration, latching, withdrawal, timeout, reset.
module tb_mem_responder;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN, ramready;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic        iwait, dwait, ramREN, ramWEN, err;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int compared   = 0;
  int mismatched = 0;

  mem_responder #(.TIMEOUT(8), .ERR_WORD(32'hBAD0BAD0)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramready(ramready), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0; ramready = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0;
    #2;
    compared++;
    if ({iwait, dwait, ramREN, ramWEN, err} !== 5'b11000) begin
      mismatched++;
      $display("FAIL reset_ctrl: got %b want 11000", {iwait, dwait, ramREN, ramWEN, err});
    end
    compared++;
    if ({iload, dload, ramaddr, ramstore} !== 128'h0) begin
      mismatched++;
      $display("FAIL reset_data: got %h want 0", {iload, dload, ramaddr, ramstore});
    end
    tick; tick;
    nRST = 1'b1;
  endtask

  task automatic test_icache_read;
    iREN = 1; iaddr = 32'h40;
    #1;
    compared++;
    if (ramREN !== 1'b0) begin
      mismatched++;
      $display("FAIL icache_idle_strobe: got %b want 0", ramREN);
    end
    tick;
    for (int i = 1; i <= 3; i++) begin
      if (i == 2) iaddr = 32'h44;
      if (i == 3) begin ramready = 1; ramload = 32'h2002_0001; end
      #1;
      compared++;
      if ({ramREN, ramWEN, ramaddr} !== {2'b10, 32'h40}) begin
        mismatched++;
        $display("FAIL icache_ram_c%0d: got %b/%b/%h want 1/0/40", i, ramREN, ramWEN, ramaddr);
      end
      compared++;
      if ({iwait, dwait} !== {(i != 3), 1'b1}) begin
        mismatched++;
        $display("FAIL icache_wait_c%0d: got %b%b want %b1", i, iwait, dwait, (i != 3));
      end
      if (i == 3) begin
        compared++;
        if (iload !== 32'h2002_0001) begin
          mismatched++;
          $display("FAIL icache_load: got %h want 20020001", iload);
        end
      end
      tick;
    end
    iREN = 0; ramready = 0;
    #1;
    compared++;
    if ({iwait, ramREN} !== 2'b10) begin
      mismatched++;
      $display("FAIL icache_after: got %b want 10", {iwait, ramREN});
    end
  endtask

  task automatic test_write_priority;
    dWEN = 1; dREN = 1; daddr = 32'h80; dstore = 32'hDEAD_BEEF;
    #1;
    compared++;
    if ({dwait, ramWEN} !== 2'b10) begin
      mismatched++;
      $display("FAIL write_idle: got %b want 10", {dwait, ramWEN});
    end
    tick;
    daddr = 32'h999; dstore = 32'h0; ramready = 1; ramload = 32'h1234_5678;
    #1;
    compared++;
    if ({ramWEN, ramREN, ramaddr, ramstore} !== {2'b10, 32'h80, 32'hDEAD_BEEF}) begin
      mismatched++;
      $display("FAIL write_ram: got %b%b/%h/%h want 10/80/deadbeef", ramWEN, ramREN, ramaddr, ramstore);
    end
    compared++;
    if ({dwait, iwait, dload} !== {2'b01, 32'h0}) begin
      mismatched++;
      $display("FAIL write_done: got %b%b/%h want 01/0", dwait, iwait, dload);
    end
    tick;
    dWEN = 0; dREN = 0; ramready = 0;
    #1;
    compared++;
    if ({dwait, ramWEN} !== 2'b10) begin
      mismatched++;
      $display("FAIL write_after: got %b want 10", {dwait, ramWEN});
    end
  endtask

  task automatic test_back_to_back;
    tick;
    nRST = 0;
    #1;
    nRST = 1;
    iREN = 1; dREN = 1; iaddr = 32'h100; daddr = 32'h200; ramready = 1; ramload = 32'h55;
    for (int c = 0; c < 8; c++) begin
      logic exp_i, exp_d, exp_ren;
      logic [31:0] exp_addr;
      exp_d    = !((c % 4) == 1);
      exp_i    = !((c % 4) == 3);
      exp_ren  = (c % 2) == 1;
      exp_addr = ((c % 4) == 1) ? 32'h200 : ((c % 4) == 3) ? 32'h100 : 32'h0;
      #1;
      compared++;
      if ({iwait, dwait, ramREN, ramaddr} !== {exp_i, exp_d, exp_ren, exp_addr}) begin
        mismatched++;
        $display("FAIL b2b_c%0d: got %b%b%b/%h want %b%b%b/%h", c, iwait, dwait, ramREN, ramaddr,
                 exp_i, exp_d, exp_ren, exp_addr);
      end
      tick;
    end
    iREN = 0; dREN = 0; ramready = 0;
  endtask

  task automatic test_withdraw;
    iREN = 1; iaddr = 32'h300;
    tick;
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) iREN = 0;
      #1;
      compared++;
      if ({ramREN, iwait} !== 2'b11) begin
        mismatched++;
        $display("FAIL withdraw_c%0d: got %b want 11", c, {ramREN, iwait});
      end
      tick;
    end
    #1;
    compared++;
    if ({ramREN, iwait, err} !== 3'b010) begin
      mismatched++;
      $display("FAIL withdraw_after: got %b want 010", {ramREN, iwait, err});
    end
    iREN = 1; dREN = 1; ramready = 1;
    tick;
    #1;
    compared++;
    if ({dwait, iwait, ramaddr} !== {2'b01, 32'h200}) begin
      mismatched++;
      $display("FAIL withdraw_lastd: got %b%b/%h want 01/200", dwait, iwait, ramaddr);
    end
    tick;
    iREN = 0; dREN = 0; ramready = 0;
  endtask

  task automatic test_timeout;
    dREN = 1; daddr = 32'h400;
    tick;
    for (int k = 1; k <= 8; k++) begin
      #1;
      compared++;
      if ({dwait, err} !== {(k != 8), 1'b0}) begin
        mismatched++;
        $display("FAIL timeout_c%0d: got %b want %b0", k, {dwait, err}, (k != 8));
      end
      if (k == 8) begin
        compared++;
        if (dload !== 32'hBAD0_BAD0) begin
          mismatched++;
          $display("FAIL timeout_load: got %h want bad0bad0", dload);
        end
      end
      tick;
    end
    dREN = 0;
    #1;
    compared++;
    if ({err, dwait} !== 2'b11) begin
      mismatched++;
      $display("FAIL timeout_err: got %b want 11", {err, dwait});
    end
    tick; tick;
    compared++;
    if (err !== 1'b1) begin
      mismatched++;
      $display("FAIL timeout_sticky: got %b want 1", err);
    end
  endtask

  task automatic test_reset_mid_access;
    dWEN = 1; daddr = 32'h500; dstore = 32'hCAFE_F00D;
    tick;
    #1;
    compared++;
    if ({ramWEN, ramaddr} !== {1'b1, 32'h500}) begin
      mismatched++;
      $display("FAIL rstmid_pre: got %b/%h want 1/500", ramWEN, ramaddr);
    end
    #2;
    nRST = 0;
    #1;
    compared++;
    if ({ramWEN, ramREN, iwait, dwait, err, ramaddr, ramstore} !== {5'b00110, 64'h0}) begin
      mismatched++;
      $display("FAIL rstmid: got %b%b%b%b%b/%h/%h want 00110/0/0", ramWEN, ramREN, iwait, dwait, err,
               ramaddr, ramstore);
    end
    dWEN = 0;
    tick;
    nRST = 1;
    tick;
    #1;
    compared++;
    if ({ramWEN, dwait, err} !== 3'b010) begin
      mismatched++;
      $display("FAIL rstmid_after: got %b want 010", {ramWEN, dwait, err});
    end
  endtask

  initial begin
    test_reset;
    test_icache_read;
    test_write_priority;
    test_back_to_back;
    test_withdraw;
    test_timeout;
    test_reset_mid_access;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
